tag_checker: RTL

TAG_CHECKER -- requirements
Module: tag_checker

---
 rtl/tag_checker.sv | 114 +++++++++++
 1 files changed

// File: rtl/tag_checker.sv
// Tag lookup engine for a direct-mapped cache. Pops one request at a time,
// reads the tag RAM, decides hit/miss, updates the tag and hands one result downstream.
module tag_checker #(
  parameter int ADDR_WIDTH  = 64,
  parameter int ID_WIDTH    = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fifo_empty_i,
  output logic                          fifo_rden_o,
  input  logic [ADDR_WIDTH+ID_WIDTH:0]  fifo_rdata_i,
  output logic [INDEX_WIDTH-1:0]        tag_raddr_o,
  input  logic [TAG_WIDTH+1:0]          tag_rdata_i,
  output logic                          tag_wen_o,
  output logic [INDEX_WIDTH-1:0]        tag_waddr_o,
  output logic [TAG_WIDTH+1:0]          tag_wdata_o,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic                          result_hit_o,
  output logic                          result_write_o,
  output logic [ID_WIDTH-1:0]           result_id_o,
  output logic [ADDR_WIDTH-1:0]         result_addr_o,
  output logic                          result_victim_dirty_o,
  output logic [TAG_WIDTH-1:0]          result_victim_tag_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOOKUP  = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  logic [2:0]             state;
  logic                   req_rw;
  logic [ID_WIDTH-1:0]    req_id;
  logic [ADDR_WIDTH-1:0]  req_addr;

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   ram_valid;
  logic                   ram_dirty;
  logic [TAG_WIDTH-1:0]   ram_tag;
  logic                   hit;

  assign req_idx   = req_addr[INDEX_WIDTH-1:0];
  assign req_tag   = req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign ram_valid = tag_rdata_i[TAG_WIDTH+1];
  assign ram_dirty = tag_rdata_i[TAG_WIDTH];
  assign ram_tag   = tag_rdata_i[TAG_WIDTH-1:0];
  assign hit       = ram_valid && (ram_tag == req_tag);

  assign tag_raddr_o    = req_idx;
  assign result_valid_o = (state == S_OUT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= S_IDLE;
      req_rw                <= 1'b0;
      req_id                <= '0;
      req_addr              <= '0;
      result_hit_o          <= 1'b0;
      result_write_o        <= 1'b0;
      result_id_o           <= '0;
      result_addr_o         <= '0;
      result_victim_dirty_o <= 1'b0;
      result_victim_tag_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty_i) state <= S_FETCH;
        end
        S_FETCH: begin
          // Popped entry is valid one cycle after the read strobe.
          req_rw   <= fifo_rdata_i[ADDR_WIDTH+ID_WIDTH];
          req_id   <= fifo_rdata_i[ADDR_WIDTH+ID_WIDTH-1:ADDR_WIDTH];
          req_addr <= fifo_rdata_i[ADDR_WIDTH-1:0];
          state    <= S_LOOKUP;
        end
        S_LOOKUP: begin
          state <= S_COMPARE;
        end
        S_COMPARE: begin
          result_hit_o          <= hit;
          result_write_o        <= req_rw;
          result_id_o           <= req_id;
          result_addr_o         <= req_addr;
          result_victim_dirty_o <= !hit && ram_valid && ram_dirty;
          result_victim_tag_o   <= (!hit && ram_valid) ? ram_tag : '0;
          state                 <= S_OUT;
        end
        S_OUT: begin
          if (result_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are gated by rst_n so nothing leaks out while reset is held mid-flight.
  always_comb begin
    fifo_rden_o = rst_n && (state == S_IDLE) && !fifo_empty_i;
    tag_wen_o   = rst_n && (state == S_COMPARE) && (req_rw || !hit);
    tag_waddr_o = '0;
    tag_wdata_o = '0;
    if (tag_wen_o) begin
      // A hit keeps the tag it matched; a miss installs the request tag.
      tag_waddr_o = req_idx;
      tag_wdata_o = {1'b1, req_rw, req_tag};
    end
  end

endmodule
